// File: rtl/snake_pkg.sv
// Shared definitions for the Digital Snake controller: FSM state width and encodings.
package snake_pkg;
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_COUNTDOWN = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN       = 3'd2;
    localparam logic [STATE_W-1:0] ST_PAUSE     = 3'd3;
    localparam logic [STATE_W-1:0] ST_LIFE_LOST = 3'd4;
    localparam logic [STATE_W-1:0] ST_GAME_OVER = 3'd5;
endpackage

// File: rtl/snake_game_ctrl_btn_rise.sv
// Rising-edge detector for a debounced button level.
module btn_rise (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    logic btn_q;

    // NOTE: history resets to 1 so a button already held when reset releases yields no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) btn_q <= 1'b1;
        else     btn_q <= btn;
    end

    assign rise = btn & ~btn_q;
endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game flow controller: lives, countdown, level progression and timed game-over hold.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int CD_TICKS       = 3,
    parameter int OVER_TICKS     = 8,
    parameter int APPLES_PER_LVL = 5,
    parameter int LVL_MAX        = 7,
    localparam int LIFE_W        = $clog2(LIVES + 1),
    localparam int LVL_W         = $clog2(LVL_MAX + 1),
    localparam int CD_W          = $clog2(CD_TICKS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start_btn,
    input  logic              pause_btn,
    input  logic              dead_in,
    input  logic              apple_in,
    output logic [2:0]        state,
    output logic              run_en,
    output logic              respawn,
    output logic              game_over,
    output logic [LIFE_W-1:0] lives,
    output logic [LVL_W-1:0]  level,
    output logic [CD_W-1:0]   cd_val
);
    localparam int APL_W  = $clog2(APPLES_PER_LVL + 1);
    localparam int HOLD_W = $clog2(OVER_TICKS + 1);

    localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);
    localparam logic [LIFE_W-1:0] LIFE_LAST  = LIFE_W'(1);
    localparam logic [LVL_W-1:0]  LVL_FIRST  = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_TOP    = LVL_W'(LVL_MAX);
    localparam logic [CD_W-1:0]   CD_INIT    = CD_W'(CD_TICKS);
    localparam logic [CD_W-1:0]   CD_LAST    = CD_W'(1);
    localparam logic [APL_W-1:0]  APL_LAST   = APL_W'(APPLES_PER_LVL - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(OVER_TICKS);

    logic start_rise, pause_rise;

    btn_rise u_start_rise (.clk(clk), .rst(rst), .btn(start_btn), .rise(start_rise));
    btn_rise u_pause_rise (.clk(clk), .rst(rst), .btn(pause_btn), .rise(pause_rise));

    logic [2:0]        state_nxt;
    logic [LIFE_W-1:0] lives_nxt;
    logic [LVL_W-1:0]  level_nxt;
    logic [CD_W-1:0]   cd_nxt;
    logic [APL_W-1:0]  apple_cnt, apple_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              respawn_nxt, game_over_nxt;

    // NOTE: every combinational output takes a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        lives_nxt     = lives;
        level_nxt     = level;
        cd_nxt        = cd_val;
        apple_nxt     = apple_cnt;
        hold_nxt      = hold_cnt;
        respawn_nxt   = 1'b0;
        game_over_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    state_nxt   = ST_COUNTDOWN;
                    lives_nxt   = LIVES_INIT;
                    level_nxt   = LVL_FIRST;
                    apple_nxt   = '0;
                    cd_nxt      = CD_INIT;
                    respawn_nxt = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (cd_val == CD_LAST) begin
                        state_nxt = ST_RUN;
                        cd_nxt    = '0;
                    end else begin
                        cd_nxt = cd_val - 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (dead_in) begin
                    lives_nxt = lives - 1'b1;
                    if (lives == LIFE_LAST) begin
                        state_nxt     = ST_GAME_OVER;
                        game_over_nxt = 1'b1;
                        hold_nxt      = HOLD_INIT;
                    end else begin
                        state_nxt = ST_LIFE_LOST;
                    end
                end else if (start_rise) begin
                    state_nxt = ST_IDLE;
                end else begin
                    // A pause edge still lets an apple from the same clock count.
                    if (pause_rise) state_nxt = ST_PAUSE;
                    if (apple_in) begin
                        if (apple_cnt == APL_LAST) begin
                            apple_nxt = '0;
                            if (level != LVL_TOP) level_nxt = level + 1'b1;
                        end else begin
                            apple_nxt = apple_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (start_rise) begin
                    state_nxt = ST_IDLE;
                end else if (pause_rise) begin
                    state_nxt = ST_COUNTDOWN;
                    cd_nxt    = CD_INIT;
                end
            end
            ST_LIFE_LOST: begin
                state_nxt   = ST_COUNTDOWN;
                cd_nxt      = CD_INIT;
                respawn_nxt = 1'b1;
            end
            ST_GAME_OVER: begin
                if (tick && hold_cnt != '0) hold_nxt = hold_cnt - 1'b1;
                if (start_rise && hold_cnt == '0) begin
                    state_nxt = ST_IDLE;
                    lives_nxt = LIVES_INIT;
                    level_nxt = LVL_FIRST;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            run_en    <= 1'b0;
            respawn   <= 1'b0;
            game_over <= 1'b0;
            lives     <= LIVES_INIT;
            level     <= LVL_FIRST;
            cd_val    <= '0;
            apple_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            run_en    <= (state_nxt == ST_RUN);
            respawn   <= respawn_nxt;
            game_over <= game_over_nxt;
            lives     <= lives_nxt;
            level     <= level_nxt;
            cd_val    <= cd_nxt;
            apple_cnt <= apple_nxt;
            hold_cnt  <= hold_nxt;
        end
    end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed and randomized checks of snake_game_ctrl against a rule-level reference model.
module tb_snake_game_ctrl;
    localparam int LIVES = 3, CD_TICKS = 3, OVER_TICKS = 8, APPLES_PER_LVL = 5, LVL_MAX = 7;
    localparam int IDLE = 0, COUNTDOWN = 1, RUN = 2, PAUSE = 3, LIFE_LOST = 4, GAME_OVER = 5;

    logic       clk = 1'b0, rst = 1'b1;
    logic       tick = 1'b0, start_btn = 1'b0, pause_btn = 1'b0, dead_in = 1'b0, apple_in = 1'b0;
    logic [2:0] state;
    logic       run_en, respawn, game_over;
    logic [1:0] lives;
    logic [2:0] level;
    logic [1:0] cd_val;

    int errors = 0, checks = 0;

    snake_game_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .start_btn(start_btn), .pause_btn(pause_btn),
        .dead_in(dead_in), .apple_in(apple_in), .state(state), .run_en(run_en),
        .respawn(respawn), .game_over(game_over), .lives(lives), .level(level), .cd_val(cd_val)
    );

    always #5 clk = ~clk;

    // Reference model: game rules with plain integers; level derives from apples eaten this game.
    int m_state, m_lives, m_apples, m_cd, m_hold;
    bit m_respawn, m_go, m_start_q, m_pause_q;

    function automatic int m_level();
        int l = 1 + m_apples / APPLES_PER_LVL;
        return (l > LVL_MAX) ? LVL_MAX : l;
    endfunction

    function automatic void model_reset();
        m_state = IDLE; m_lives = LIVES; m_apples = 0; m_cd = 0; m_hold = 0;
        m_respawn = 0; m_go = 0; m_start_q = 1; m_pause_q = 1;
    endfunction

    function automatic void model_step(bit t, bit s, bit p, bit d, bit a);
        bit s_rise = s && !m_start_q;
        bit p_rise = p && !m_pause_q;
        m_start_q = s; m_pause_q = p;
        m_respawn = 0; m_go = 0;
        if (m_state == IDLE) begin
            if (s_rise) begin
                m_state = COUNTDOWN; m_cd = CD_TICKS; m_respawn = 1;
                m_lives = LIVES; m_apples = 0;
            end
        end else if (m_state == COUNTDOWN) begin
            if (t) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) m_state = RUN;
            end
        end else if (m_state == RUN) begin
            if (d) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) begin m_state = GAME_OVER; m_go = 1; m_hold = OVER_TICKS; end
                else m_state = LIFE_LOST;
            end else if (s_rise) m_state = IDLE;
            else begin
                if (p_rise) m_state = PAUSE;
                if (a) m_apples = m_apples + 1;
            end
        end else if (m_state == PAUSE) begin
            if (s_rise) m_state = IDLE;
            else if (p_rise) begin m_state = COUNTDOWN; m_cd = CD_TICKS; end
        end else if (m_state == LIFE_LOST) begin
            m_state = COUNTDOWN; m_cd = CD_TICKS; m_respawn = 1;
        end else if (m_state == GAME_OVER) begin
            int h0 = m_hold;
            if (t && m_hold > 0) m_hold = m_hold - 1;
            if (s_rise && h0 == 0) begin m_state = IDLE; m_lives = LIVES; m_apples = 0; end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"}, 32'(state), m_state);
        check({tag, ".run_en"}, 32'(run_en), 32'(m_state == RUN));
        check({tag, ".respawn"}, 32'(respawn), 32'(m_respawn));
        check({tag, ".game_over"}, 32'(game_over), 32'(m_go));
        check({tag, ".lives"}, 32'(lives), m_lives);
        check({tag, ".level"}, 32'(level), m_level());
        check({tag, ".cd_val"}, 32'(cd_val), m_cd);
    endtask

    // One clock: apply inputs, advance model, sample after the edge. Button levels persist.
    task automatic step(input string tag, input bit t, input bit s, input bit p, input bit d, input bit a);
        tick = t; start_btn = s; pause_btn = p; dead_in = d; apple_in = a;
        model_step(t, s, p, d, a);
        @(posedge clk); #1;
        compare_all(tag);
        tick = 0; dead_in = 0; apple_in = 0;
    endtask

    task automatic ticks_to_run(input string tag);
        for (int i = 0; i < CD_TICKS; i++) step(tag, 1, start_btn, pause_btn, 0, 0);
        check({tag, ".in_run"}, 32'(state), RUN);
    endtask

    initial begin
        model_reset();
        #12;
        compare_all("reset");
        check("reset.lives_const", 32'(lives), 3);
        @(posedge clk); #1; rst = 0;
        step("idle", 0, 0, 0, 0, 0);

        // 1: start held 3 clocks gives one countdown entry
        step("t1.start", 0, 1, 0, 0, 0);
        check("t1.cd_init", 32'(cd_val), 3);
        check("t1.respawn", 32'(respawn), 1);
        step("t1.hold1", 0, 1, 0, 0, 0);
        check("t1.respawn_clr", 32'(respawn), 0);
        step("t1.hold2", 0, 1, 0, 0, 0);
        step("t1.tick1", 1, 0, 0, 0, 0);
        check("t1.cd2", 32'(cd_val), 2);
        step("t1.tick2", 1, 0, 0, 0, 0);
        check("t1.cd1", 32'(cd_val), 1);
        step("t1.tick3", 1, 0, 0, 0, 0);
        check("t1.run_en", 32'(run_en), 1);
        check("t1.cd0", 32'(cd_val), 0);

        // 2: level progression and saturation
        for (int i = 0; i < 5; i++) step("t2.apple", 0, 0, 0, 0, 1);
        check("t2.level2", 32'(level), 2);
        for (int i = 0; i < 40; i++) step("t2.apple_more", 0, 0, 0, 0, 1);
        check("t2.level_sat", 32'(level), 7);

        // 3: deaths down to game over
        step("t3.dead1", 0, 0, 0, 1, 0);
        check("t3.life_lost", 32'(state), LIFE_LOST);
        check("t3.lives2", 32'(lives), 2);
        step("t3.relaunch", 0, 0, 0, 0, 0);
        check("t3.respawn", 32'(respawn), 1);
        check("t3.cd3", 32'(cd_val), 3);
        ticks_to_run("t3.cd_a");
        step("t3.dead2", 0, 0, 0, 1, 0);
        step("t3.relaunch2", 0, 0, 0, 0, 0);
        ticks_to_run("t3.cd_b");
        step("t3.dead3", 0, 0, 0, 1, 0);
        check("t3.game_over_state", 32'(state), GAME_OVER);
        check("t3.lives0", 32'(lives), 0);
        check("t3.go_pulse", 32'(game_over), 1);
        step("t3.go_clr", 0, 0, 0, 0, 0);
        check("t3.go_pulse_clr", 32'(game_over), 0);

        // 4: game-over hold
        for (int i = 0; i < 7; i++) step("t4.tick", 1, 0, 0, 0, 0);
        step("t4.early_start", 0, 1, 0, 0, 0);
        check("t4.ignored", 32'(state), GAME_OVER);
        step("t4.release", 0, 0, 0, 0, 0);
        step("t4.tick8", 1, 0, 0, 0, 0);
        step("t4.start", 0, 1, 0, 0, 0);
        check("t4.idle", 32'(state), IDLE);
        check("t4.lives3", 32'(lives), 3);
        check("t4.level1", 32'(level), 1);

        // 5: pause behaviour
        step("t5.release", 0, 0, 0, 0, 0);
        step("t5.start", 0, 1, 0, 0, 0);
        ticks_to_run("t5.cd");
        step("t5.pause", 0, 1, 1, 0, 0);
        check("t5.paused", 32'(state), PAUSE);
        check("t5.run_en0", 32'(run_en), 0);
        step("t5.ignored", 1, 1, 1, 1, 1);
        step("t5.ignored2", 1, 1, 0, 1, 1);
        check("t5.still_paused", 32'(lives), 3);
        step("t5.resume", 0, 1, 1, 0, 0);
        check("t5.countdown", 32'(state), COUNTDOWN);
        check("t5.no_respawn", 32'(respawn), 0);
        ticks_to_run("t5.cd2");
        step("t5.pause2", 0, 1, 0, 0, 0);
        step("t5.pause3", 0, 0, 1, 0, 0);
        step("t5.abort", 0, 1, 1, 0, 0);
        check("t5.abort_idle", 32'(state), IDLE);

        // 6: same-clock priority, async reset, start held across reset
        step("t6.release", 0, 0, 0, 0, 0);
        step("t6.start", 0, 1, 0, 0, 0);
        ticks_to_run("t6.cd");
        step("t6.apple1", 0, 1, 0, 0, 1);
        step("t6.apple2", 0, 1, 0, 0, 1);
        step("t6.combo", 0, 1, 1, 1, 1);
        check("t6.life_lost", 32'(state), LIFE_LOST);
        step("t6.relaunch", 0, 1, 0, 0, 0);
        ticks_to_run("t6.cd2");
        step("t6.apple3", 0, 1, 0, 0, 1);
        step("t6.apple4", 0, 1, 0, 0, 1);
        check("t6.level_still1", 32'(level), 1);
        step("t6.apple5", 0, 1, 0, 0, 1);
        check("t6.level2", 32'(level), 2);
        step("t6.dead", 0, 1, 0, 1, 0);
        step("t6.to_cd", 0, 1, 0, 0, 0);
        #2; rst = 1; #1;
        model_reset();
        compare_all("t6.async_rst");
        check("t6.rst_idle", 32'(state), IDLE);
        @(posedge clk); #1; rst = 0;
        for (int i = 0; i < 3; i++) step("t6.held_start", 0, 1, 0, 0, 0);
        check("t6.stays_idle", 32'(state), IDLE);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            bit t, s, p, d, a;
            t = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 15) == 0) ? ~start_btn : start_btn;
            p = ($urandom_range(0, 11) == 0) ? ~pause_btn : pause_btn;
            d = ($urandom_range(0, 24) == 0);
            a = ($urandom_range(0, 3) == 0);
            if (s && !m_start_q) a = 0;
            step("rand", t, s, p, d, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
